// File: rtl/seq_restoring_div_if.sv
// Start/done operand and result bundle for the sequential restoring divider.
// The master drives the operands and start; the divider (slave) returns status and results.
interface seq_restoring_div_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_div.sv
// Unsigned sequential restoring divider producing one quotient bit per clock.
// Each trial subtraction is a WIDTH+1-bit ripple of full-adder cells (inverted divisor, carry-in 1).
module seq_restoring_div #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_restoring_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (a & ci) | (b & ci);
  endfunction

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  // R stays below the divisor after every step, so its top bit is always 0 and is not stored.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remout;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH+1:0] w_c;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_a    = {r_rem, r_q[WIDTH-1]};
  assign w_b    = ~{1'b0, r_div};
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    assign w_t[i]   = fa_sum(w_a[i], w_b[i], w_c[i]);
    assign w_c[i+1] = fa_carry(w_a[i], w_b[i], w_c[i]);
  end
  // The sum of the top cell is provably 0 whenever there is no borrow; only its carry matters.
  assign w_c[WIDTH+1] = fa_carry(w_a[WIDTH], w_b[WIDTH], w_c[WIDTH]);

  assign w_no_borrow = w_c[WIDTH+1];
  assign w_rem_nxt   = w_no_borrow ? w_t : w_a[WIDTH-1:0];
  assign w_q_nxt     = {r_q[WIDTH-2:0], w_no_borrow};

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remout;
  assign bus.div_by_zero = r_dbz;

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= {CW{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
      r_quot   <= {WIDTH{1'b0}};
      r_remout <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_div <= bus.divisor;
            if (bus.divisor == {WIDTH{1'b0}}) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_quot   <= {WIDTH{1'b1}};
              r_remout <= bus.dividend;
              r_dbz    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_count <= {CW{1'b0}};
              r_rem   <= {WIDTH{1'b0}};
              r_q     <= bus.dividend;
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_rem   <= w_rem_nxt;
          r_q     <= w_q_nxt;
          r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
          if (r_count == CW'(WIDTH - 1)) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_quot   <= w_q_nxt;
            r_remout <= w_rem_nxt;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
